crossbar_slave_mem: RTL and testbench

//   Word-addressed memory that responds on the slave side of the crossbar bus.
//   It accepts the crossbar's req/addr/cmd/wdata and returns a one-cycle ack, then

---
 rtl/crossbar_slave_mem.sv | 115 +++++++++++
 tb/tb_crossbar_slave_mem.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/crossbar_slave_mem.sv
// crossbar_slave_mem
//   Word-addressed memory behind one crossbar slave port. A request is held
//   by the master until a one-cycle ack. The ack is delayed by WAIT_CYCLES
//   wait states. A write takes effect at the edge that closes the ack cycle.
//   Read data appears on rdata in the cycle after the read ack.
//
// Ports
//   clk    in   1   rising-edge clock
//   rst_n  in   1   asynchronous active-low reset
//   req    in   1   transaction request from the crossbar
//   addr   in  32   byte address; only addr[ADDR_W+1:2] selects the word
//   cmd    in   1   0 = read, 1 = write
//   wdata  in  32   write data, held with req
//   ack    out  1   one-cycle accept pulse (registered)
//   rdata  out 32   read data, updated only by a read ack (registered)
module crossbar_slave_mem #(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic        cmd,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    // Counter preload on leaving IDLE. When WAIT_CYCLES is zero the WAIT
    // state is never entered, so the value is irrelevant.
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ack_q;
    logic [31:0]       rdata_q;
    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic              unused_addr;

    // The upper bits are decoded by the crossbar. The byte lane is ignored.
    // The memory therefore aliases every DEPTH*4 bytes.
    assign idx         = addr[ADDR_W+1:2];
    assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_ACK;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                // A withdrawn request wins over an expiring counter.
                // A dropped req never gets acked.
                if (!req) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= (state_d == S_ACK);
            if (state_q == S_ACK && !cmd) begin
                rdata_q <= mem[idx];
            end
        end
    end

    // The array is not reset. Reset forces state_q out of ACK asynchronously,
    // so a write whose closing edge has not yet occurred is dropped.
    always_ff @(posedge clk) begin
        if (state_q == S_ACK && cmd) begin
            mem[idx] <= wdata;
        end
    end

    assign ack   = ack_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_crossbar_slave_mem.sv
module tb_crossbar_slave_mem;

    localparam int W = 2;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, cmd, req0, cmd0;
    logic [31:0] addr, wdata, addr0, wdata0;
    logic        ack, ack0;
    logic [31:0] rdata, rdata0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t q_main[$];
    exp_t q_w0[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    crossbar_slave_mem #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .cmd(cmd),
        .wdata(wdata), .ack(ack), .rdata(rdata)
    );

    crossbar_slave_mem #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .addr(addr0), .cmd(cmd0),
        .wdata(wdata0), .ack(ack0), .rdata(rdata0)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor for the WAIT_CYCLES=2 instance. Every ack must match the head
    // of the queue in cycle number. rdata is checked one cycle later.
    logic        rd_pend = 1'b0;
    logic [31:0] rd_exp;
    always @(negedge clk) begin
        exp_t e;
        if (rd_pend) begin
            check("rdata", rdata, rd_exp);
            rd_pend = 1'b0;
        end
        if (ack === 1'b1) begin
            if (q_main.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack got ack=1 want ack=0 (cycle %0d)", cyc);
            end else begin
                e = q_main.pop_front();
                check("ack_cycle", 32'(cyc), 32'(e.cyc));
                rd_exp  = e.rdata;
                rd_pend = 1'b1;
            end
        end
    end

    logic        rd_pend0 = 1'b0;
    logic [31:0] rd_exp0;
    always @(negedge clk) begin
        exp_t e;
        if (rd_pend0) begin
            check("w0_rdata", rdata0, rd_exp0);
            rd_pend0 = 1'b0;
        end
        if (ack0 === 1'b1) begin
            if (q_w0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL w0_unexpected_ack got ack=1 want ack=0 (cycle %0d)", cyc);
            end else begin
                e = q_w0.pop_front();
                check("w0_ack_cycle", 32'(cyc), 32'(e.cyc));
                rd_exp0  = e.rdata;
                rd_pend0 = 1'b1;
            end
        end
    end

    // Issue one transaction and push the expected ack cycle and rdata.
    // For a write, the rdata value to expect is the held prior read data.
    task automatic do_txn(input bit sel0, input bit c, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_rd);
        exp_t e;
        bit   got;
        @(posedge clk); #1;
        if (sel0) begin
            req0 = 1'b1; cmd0 = c; addr0 = a; wdata0 = wd;
            e.cyc = cyc + 1;
            e.rdata = exp_rd;
            q_w0.push_back(e);
        end else begin
            req = 1'b1; cmd = c; addr = a; wdata = wd;
            e.cyc = cyc + 1 + W;
            e.rdata = exp_rd;
            q_main.push_back(e);
        end
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = sel0 ? ack0 : ack;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout got no ack want ack within 40 cycles (addr %h)", a);
            req = 1'b0; req0 = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            req = 1'b0; req0 = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req = 1'b1; cmd = 1'b1; addr = 32'h0; wdata = 32'h5555_AAAA;
        req0 = 1'b0; cmd0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0;

        // Reset held with req=1: no ack, rdata cleared.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_ack", {31'h0, ack}, 32'h0);
        end
        check("reset_rdata", rdata, 32'h0);
        @(posedge clk); #1;
        req = 1'b0;
        rst_n = 1'b1;
        idle(2);

        // Basic write/read with WAIT_CYCLES=2.
        do_txn(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000);
        do_txn(1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF);
        idle(2);

        // Aliasing: bits above the word index and the crossbar bits are ignored.
        do_txn(1'b0, 1'b1, 32'h0000_0004, 32'h1234_5678, 32'hDEAD_BEEF);
        do_txn(1'b0, 1'b0, 32'h0000_0404, 32'h0,         32'h1234_5678);
        do_txn(1'b0, 1'b0, 32'hC000_0004, 32'h0,         32'h1234_5678);
        idle(2);

        // Back-to-back writes then reads. 0x9 also exercises ignored byte bits.
        do_txn(1'b0, 1'b1, 32'h0000_0000, 32'h0, 32'h1234_5678);
        do_txn(1'b0, 1'b1, 32'h0000_0004, 32'h1, 32'h1234_5678);
        do_txn(1'b0, 1'b1, 32'h0000_0008, 32'h2, 32'h1234_5678);
        do_txn(1'b0, 1'b1, 32'h0000_000C, 32'h3, 32'h1234_5678);
        do_txn(1'b0, 1'b0, 32'h0000_0000, 32'h0, 32'h0000_0000);
        do_txn(1'b0, 1'b0, 32'h0000_0004, 32'h0, 32'h0000_0001);
        do_txn(1'b0, 1'b0, 32'h0000_0009, 32'h0, 32'h0000_0002);
        do_txn(1'b0, 1'b0, 32'h0000_000C, 32'h0, 32'h0000_0003);
        idle(2);

        // Withdraw: req is dropped in the cycle where the counter hits zero.
        // No ack may follow, and the memory must keep DEADBEEF.
        @(posedge clk); #1;
        req = 1'b1; cmd = 1'b1; addr = 32'h0000_0010; wdata = 32'hAAAA_5555;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req = 1'b0;
        idle(8);
        do_txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF);
        idle(2);

        // WAIT_CYCLES=0: ack comes in the cycle after req.
        do_txn(1'b1, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 32'h0000_0000);
        do_txn(1'b1, 1'b0, 32'h0000_0020, 32'h0,         32'hCAFE_F00D);
        idle(2);

        // Reset during WAIT of a write: the write is discarded.
        do_txn(1'b0, 1'b1, 32'h0000_001C, 32'h0000_0001, 32'hDEAD_BEEF);
        idle(2);
        @(posedge clk); #1;
        req = 1'b1; cmd = 1'b1; addr = 32'h0000_001C; wdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        rst_n = 1'b0;
        req = 1'b0;
        idle(3);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_ack", {31'h0, ack}, 32'h0);
        check("post_reset_rdata", rdata, 32'h0);
        do_txn(1'b0, 1'b0, 32'h0000_001C, 32'h0, 32'h0000_0001);
        idle(5);

        check("main_queue_left", 32'(q_main.size()), 32'h0);
        check("w0_queue_left", 32'(q_w0.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
